// File: rtl/sm_addsub_pkg.sv
// Shared widths, op encoding and sign helpers for the sign-magnitude add/sub pipe.
package sm_addsub_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    function automatic int word_w(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int mag_w(input int xlen);
        return 2 * xlen - 1;
    endfunction

    // A zero magnitude always carries a positive sign, so -0 never propagates.
    function automatic logic norm_sign(input logic sign, input logic mag_nz);
        return sign & mag_nz;
    endfunction

endpackage

// File: rtl/sm_addsub_lane.sv
// One sign-magnitude add/sub lane: S1 orders operands and decides the sign, S2 adds/subtracts and saturates.
module sm_addsub_lane
    import sm_addsub_pkg::*;
#(
    parameter int XLEN_PIXEL = 8,
    localparam int W = word_w(XLEN_PIXEL),
    localparam int M = mag_w(XLEN_PIXEL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s1_en,
    input  logic         s2_en,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out,
    output logic         ovf
);

    logic [M-1:0] a_mag, b_mag;
    logic         a_sgn, b_sgn, a_ge;

    assign a_mag = a[M-1:0];
    assign b_mag = b[M-1:0];
    assign a_sgn = norm_sign(a[W-1], |a_mag);
    assign b_sgn = norm_sign(b[W-1], |b_mag) ^ (op == OP_SUB);
    assign a_ge  = (a_mag >= b_mag);

    logic         s1_same, s1_sgn;
    logic [M-1:0] s1_big, s1_small;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_same  <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_big   <= '0;
            s1_small <= '0;
        end else if (s1_en) begin
            s1_same  <= (a_sgn == b_sgn);
            s1_sgn   <= a_ge ? a_sgn : b_sgn;
            s1_big   <= a_ge ? a_mag : b_mag;
            s1_small <= a_ge ? b_mag : a_mag;
        end
    end

    logic [M:0]   sum;
    logic [M-1:0] diff, mag;
    logic         sat;

    // Operands are ordered in S1, so the difference never underflows.
    assign sum  = {1'b0, s1_big} + {1'b0, s1_small};
    assign diff = s1_big - s1_small;
    assign sat  = s1_same & sum[M];

    always_comb begin
        mag = diff;
        if (s1_same) mag = sat ? '1 : sum[M-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            ovf <= 1'b0;
        end else if (s2_en) begin
            out <= {norm_sign(s1_sgn, |mag), mag};
            ovf <= sat;
        end
    end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Multi-lane two-stage sign-magnitude add/sub pipeline with valid/ready flow control and overflow counter.
module sm_addsub_pipe
    import sm_addsub_pkg::*;
#(
    parameter int XLEN_PIXEL = 8,
    parameter int LANES      = 4,
    parameter int CNT_W      = 16,
    localparam int W = word_w(XLEN_PIXEL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out,
    output logic [LANES-1:0]   ovf,
    output logic [CNT_W-1:0]   ovf_cnt,
    input  logic               cnt_clr
);

    logic [2:1] vld_pipe;
    logic [2:1] rdy;
    logic       s1_en, s2_en, out_fire;

    assign rdy[2]    = !vld_pipe[2] | out_ready;
    assign rdy[1]    = !vld_pipe[1] | rdy[2];
    assign in_ready  = rdy[1];
    assign s1_en     = in_valid & rdy[1];
    assign s2_en     = vld_pipe[1] & rdy[2];
    assign out_valid = vld_pipe[2];
    assign out_fire  = vld_pipe[2] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (rdy[1]) vld_pipe[1] <= in_valid;
            if (rdy[2]) vld_pipe[2] <= vld_pipe[1];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sm_addsub_lane #(.XLEN_PIXEL(XLEN_PIXEL)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .s1_en (s1_en),
            .s2_en (s2_en),
            .op    (op),
            .a     (a[i*W +: W]),
            .b     (b[i*W +: W]),
            .out   (out[i*W +: W]),
            .ovf   (ovf[i])
        );
    end

    // Clear beats a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     ovf_cnt <= '0;
        else if (cnt_clr)                               ovf_cnt <= '0;
        else if (out_fire && (|ovf) && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
    end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: directed corner cases plus a randomized stream against a signed-integer model.
module tb_sm_addsub_pipe;

    localparam int XLEN_PIXEL = 8;
    localparam int LANES      = 4;
    localparam int CNT_W      = 16;
    localparam int W          = 2 * XLEN_PIXEL;
    localparam int M          = W - 1;
    localparam int LW         = LANES * W;
    localparam int MAXMAG     = (1 << M) - 1;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk, rst_n;
    logic              in_valid, in_ready, op;
    logic [LW-1:0]     a, b, out;
    logic              out_valid, out_ready, cnt_clr;
    logic [LANES-1:0]  ovf;
    logic [CNT_W-1:0]  ovf_cnt;

    sm_addsub_pipe #(.XLEN_PIXEL(XLEN_PIXEL), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               cnt_model = 0;
    bit               acc;
    logic [LW-1:0]    q_out[$];
    logic [LANES-1:0] q_ovf[$];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed event expected none", tag);
    endtask

    // Signed-integer view of each lane: compute a +/- b, clamp to the magnitude range.
    function automatic void ref_beat(input logic [LW-1:0] av, input logic [LW-1:0] bv, input logic o,
                                     output logic [LW-1:0] rv, output logic [LANES-1:0] fv);
        for (int i = 0; i < LANES; i++) begin
            logic [W-1:0] x, y;
            int va, vb, r, mag;
            x  = av[i*W +: W];
            y  = bv[i*W +: W];
            va = x[W-1] ? -int'(x[M-1:0]) : int'(x[M-1:0]);
            vb = y[W-1] ? -int'(y[M-1:0]) : int'(y[M-1:0]);
            r  = o ? va + vb : va - vb;
            fv[i] = 1'b0;
            if (r > MAXMAG)  begin r = MAXMAG;  fv[i] = 1'b1; end
            if (r < -MAXMAG) begin r = -MAXMAG; fv[i] = 1'b1; end
            mag = (r < 0) ? -r : r;
            rv[i*W +: W] = {(r < 0), mag[M-1:0]};
        end
    endfunction

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        logic [LW-1:0]    eo;
        logic [LANES-1:0] ef;
        bit               inc;
        @(negedge clk);
        acc = 1'b0;
        inc = 1'b0;
        if (rst_n) begin
            chk("ovf_cnt_track", LW'(ovf_cnt), LW'(cnt_model));
            if (in_valid && in_ready) begin
                ref_beat(a, b, op, eo, ef);
                q_out.push_back(eo);
                q_ovf.push_back(ef);
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q_out.size() == 0) fail_now("unexpected_beat");
                else begin
                    eo = q_out.pop_front();
                    ef = q_ovf.pop_front();
                    chk("out", out, eo);
                    chk("ovf", LW'(ovf), LW'(ef));
                    inc = |ef;
                end
            end
            if (cnt_clr) cnt_model = 0;
            else if (inc && cnt_model < CNT_MAX) cnt_model++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        w = W'($urandom);
        case ($urandom_range(3))
            0: w[M-1:0] = M'(MAXMAG - $urandom_range(255));
            1: w[M-1:0] = '0;
            default: ;
        endcase
        return w;
    endfunction

    task automatic new_beat();
        for (int i = 0; i < LANES; i++) begin
            a[i*W +: W] = rnd_word();
            b[i*W +: W] = rnd_word();
            if ($urandom_range(3) == 0) b[i*W +: M] = a[i*W +: M];
        end
        op = 1'($urandom);
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] al, input logic [W-1:0] bl,
                           input logic o, input logic [W-1:0] want, input logic want_ovf);
        a = '0; b = '0;
        a[W-1:0] = al; b[W-1:0] = bl; op = o;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, LW'(out_valid), LW'(1'b0));
        cycle();
        chk({tag, "_lat2"}, LW'(out_valid), LW'(1'b1));
        chk(tag, LW'(out[W-1:0]), LW'(want));
        chk({tag, "_ovf0"}, LW'(ovf[0]), LW'(want_ovf));
        cycle();
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < 10 && q_out.size() != 0; c++) cycle();
        if (q_out.size() != 0) fail_now({tag, "_drain_timeout"});
    endtask

    initial begin
        int accepted;
        logic [LW-1:0] snap;
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #2;
        chk("rst_out_valid", LW'(out_valid), '0);
        chk("rst_in_ready", LW'(in_ready), LW'(1'b1));
        chk("rst_out", out, '0);
        chk("rst_ovf_cnt", LW'(ovf_cnt), '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run_one("sub_pos",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
        run_one("sub_neg",   16'h0003, 16'h0005, 1'b0, 16'h8002, 1'b0);
        run_one("sub_eqneg", 16'h8007, 16'h8007, 1'b0, 16'h0000, 1'b0);
        run_one("add_cancel",16'h0007, 16'h8007, 1'b1, 16'h0000, 1'b0);
        run_one("sub_negz",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0);
        chk("cnt_before_ovf", LW'(ovf_cnt), '0);
        run_one("sat",       16'h7FFF, 16'h8001, 1'b0, 16'h7FFF, 1'b1);
        chk("cnt_after_ovf", LW'(ovf_cnt), LW'(1));

        // Overflow beat leaves the pipe on the same edge as a clear.
        a = '0; b = '0; a[W-1:0] = 16'hFFFF; b[W-1:0] = 16'h0005; op = 1'b0;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_wins", LW'(ovf_cnt), '0);

        // Stall: two beats fill the pipe, output held for three cycles.
        out_ready = 1'b0; in_valid = 1'b1; accepted = 0;
        new_beat();
        for (int c = 0; c < 2; c++) begin
            cycle();
            if (acc) begin accepted++; new_beat(); end
        end
        chk("stall_accepted", LW'(accepted), LW'(2));
        chk("stall_in_ready", LW'(in_ready), '0);
        chk("stall_valid", LW'(out_valid), LW'(1'b1));
        snap = out;
        cycle();
        chk("stall_stable", out, snap);
        chk("stall_in_ready2", LW'(in_ready), '0);
        out_ready = 1'b1;
        #1;
        chk("no_bubble", LW'(in_ready), LW'(1'b1));
        for (int c = 0; c < 10 && accepted < 4; c++) begin
            cycle();
            if (acc) begin accepted++; new_beat(); end
        end
        chk("stall_all_in", LW'(accepted), LW'(4));
        drain("stall");

        // Reset with two beats in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        new_beat(); cycle();
        new_beat(); cycle();
        in_valid = 1'b0;
        chk("pre_rst_valid", LW'(out_valid), LW'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", LW'(out_valid), '0);
        chk("rst_mid_out", out, '0);
        chk("rst_mid_in_ready", LW'(in_ready), LW'(1'b1));
        q_out.delete(); q_ovf.delete(); cnt_model = 0;
        cycle(); cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle(); cycle();
        chk("no_stale", LW'(out_valid), '0);
        new_beat(); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_lat1", LW'(out_valid), '0);
        cycle();
        chk("post_rst_lat2", LW'(out_valid), LW'(1'b1));
        cycle();

        // Randomized stream with random backpressure and occasional clears.
        for (int c = 0; c < 300; c++) begin
            new_beat();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            cnt_clr   = ($urandom_range(40) == 0);
            cycle();
        end
        cnt_clr = 1'b0;
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
